// File: rtl/smart_press_timer_nch.sv
// N-channel press-duration timer: per-channel period counter, period tick,
// long-press level and release report with total hold time.
module smart_press_timer_nch #(
  parameter int N_CH      = 4,
  parameter int PERIOD    = 50,
  parameter int WRAP_MODE = 1,
  parameter int LONG_MS   = 1000,
  parameter int HOLD_W    = 16,
  localparam int CW       = $clog2(PERIOD + 1)
) (
  input  logic                     clk_1KHz,
  input  logic                     reset,
  input  logic [N_CH-1:0]          count_trigger,
  output logic [N_CH*CW-1:0]       count,
  output logic [N_CH-1:0]          period_tick,
  output logic [N_CH-1:0]          long_press,
  output logic [N_CH-1:0]          release_pulse,
  output logic [N_CH*HOLD_W-1:0]   release_len
);

  localparam logic [CW-1:0]     PERIOD_C = CW'(PERIOD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = '1;
  localparam logic [HOLD_W-1:0] LONG_C   = HOLD_W'(LONG_MS);

  logic [CW-1:0]     count_q [N_CH];
  logic [CW-1:0]     count_d [N_CH];
  logic [HOLD_W-1:0] hold_q  [N_CH];
  logic [HOLD_W-1:0] hold_d  [N_CH];
  logic [HOLD_W-1:0] len_q   [N_CH];
  logic [HOLD_W-1:0] len_d   [N_CH];
  logic [N_CH-1:0]   trig_prev_q, trig_prev_d;
  logic [N_CH-1:0]   tick_q, tick_d;
  logic [N_CH-1:0]   long_q, long_d;
  logic [N_CH-1:0]   rel_q, rel_d;

  always_comb begin
    count_d     = count_q;
    hold_d      = hold_q;
    len_d       = len_q;
    trig_prev_d = count_trigger;
    tick_d      = '0;
    long_d      = '0;
    rel_d       = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (count_trigger[i]) begin
        if (count_q[i] == PERIOD_C)
          count_d[i] = (WRAP_MODE != 0) ? CW'(1) : PERIOD_C;
        else
          count_d[i] = count_q[i] + CW'(1);
        // Tick only on arrival at PERIOD, so a saturated count never re-ticks
        tick_d[i] = (count_d[i] == PERIOD_C) && (count_q[i] != PERIOD_C);
        hold_d[i] = (hold_q[i] == HOLD_MAX) ? HOLD_MAX : hold_q[i] + HOLD_W'(1);
        long_d[i] = (hold_d[i] >= LONG_C);
      end else begin
        count_d[i] = '0;
        hold_d[i]  = '0;
        if (trig_prev_q[i]) begin
          rel_d[i] = 1'b1;
          len_d[i] = hold_q[i];
        end
      end
    end
  end

  // State advances on the falling edge of the 1 kHz clock
  always_ff @(negedge clk_1KHz or posedge reset) begin
    if (reset) begin
      count_q     <= '{default: '0};
      hold_q      <= '{default: '0};
      len_q       <= '{default: '0};
      trig_prev_q <= '0;
      tick_q      <= '0;
      long_q      <= '0;
      rel_q       <= '0;
    end else begin
      count_q     <= count_d;
      hold_q      <= hold_d;
      len_q       <= len_d;
      trig_prev_q <= trig_prev_d;
      tick_q      <= tick_d;
      long_q      <= long_d;
      rel_q       <= rel_d;
    end
  end

  always_comb begin
    count       = '0;
    release_len = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      count[i*CW +: CW]           = count_q[i];
      release_len[i*HOLD_W +: HOLD_W] = len_q[i];
    end
  end

  assign period_tick   = tick_q;
  assign long_press    = long_q;
  assign release_pulse = rel_q;

endmodule

// File: tb/tb_smart_press_timer_nch.sv
// Directed bench for smart_press_timer_nch across four parameter sets.
module tb_smart_press_timer_nch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // A: defaults (PERIOD 50, wrap, LONG_MS 1000, HOLD_W 16) -> CW 6
  logic        rst_a;
  logic [3:0]  trig_a;
  logic [23:0] count_a;
  logic [3:0]  tick_a, lp_a, rp_a;
  logic [63:0] len_a;
  // B: saturating
  logic        rst_o;
  logic [3:0]  trig_b;
  logic [23:0] count_b;
  logic [3:0]  tick_b, lp_b, rp_b;
  logic [63:0] len_b;
  // C: PERIOD 5, LONG_MS 10, HOLD_W 4 -> CW 3
  logic [3:0]  trig_c;
  logic [11:0] count_c;
  logic [3:0]  tick_c, lp_c, rp_c;
  logic [15:0] len_c;
  // D: single channel, PERIOD 1 -> CW 1
  logic [0:0]  trig_d;
  logic [0:0]  count_d;
  logic [0:0]  tick_d, lp_d, rp_d;
  logic [7:0]  len_d;

  smart_press_timer_nch u_a (
    .clk_1KHz(clk), .reset(rst_a), .count_trigger(trig_a), .count(count_a),
    .period_tick(tick_a), .long_press(lp_a), .release_pulse(rp_a), .release_len(len_a));

  smart_press_timer_nch #(.WRAP_MODE(0)) u_b (
    .clk_1KHz(clk), .reset(rst_o), .count_trigger(trig_b), .count(count_b),
    .period_tick(tick_b), .long_press(lp_b), .release_pulse(rp_b), .release_len(len_b));

  smart_press_timer_nch #(.PERIOD(5), .LONG_MS(10), .HOLD_W(4)) u_c (
    .clk_1KHz(clk), .reset(rst_o), .count_trigger(trig_c), .count(count_c),
    .period_tick(tick_c), .long_press(lp_c), .release_pulse(rp_c), .release_len(len_c));

  smart_press_timer_nch #(.N_CH(1), .PERIOD(1), .LONG_MS(3), .HOLD_W(8)) u_d (
    .clk_1KHz(clk), .reset(rst_o), .count_trigger(trig_d), .count(count_d),
    .period_tick(tick_d), .long_press(lp_d), .release_pulse(rp_d), .release_len(len_d));

  function automatic int cnt_a(int ch); return int'(count_a[ch*6 +: 6]);  endfunction
  function automatic int cnt_b(int ch); return int'(count_b[ch*6 +: 6]);  endfunction
  function automatic int cnt_c(int ch); return int'(count_c[ch*3 +: 3]);  endfunction
  function automatic int lena(int ch);  return int'(len_a[ch*16 +: 16]);  endfunction
  function automatic int lenb(int ch);  return int'(len_b[ch*16 +: 16]);  endfunction
  function automatic int lenc(int ch);  return int'(len_c[ch*4 +: 4]);    endfunction

  task automatic edge_wait();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_o = 1'b1;
    trig_a = '0; trig_b = '0; trig_c = '0; trig_d = '0;
    edge_wait();
    n_checks++;
    if ({count_a, tick_a, lp_a, rp_a, len_a} !== '0) begin
      n_fail++; $display("FAIL reset_a: got %h expected 0", {count_a, tick_a, lp_a, rp_a, len_a});
    end
    n_checks++;
    if ({count_c, tick_c, lp_c, rp_c, len_c} !== '0) begin
      n_fail++; $display("FAIL reset_c: got %h expected 0", {count_c, tick_c, lp_c, rp_c, len_c});
    end
    rst_a = 1'b0; rst_o = 1'b0;
    edge_wait();
    n_checks++;
    if (count_a !== '0 || rp_a !== '0) begin
      n_fail++; $display("FAIL idle_a: got count %h rp %b expected 0", count_a, rp_a);
    end
  endtask

  task automatic test_wrap_count();
    trig_a[0] = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      edge_wait();
      n_checks++;
      if (cnt_a(0) !== ((k - 1) % 50) + 1) begin
        n_fail++; $display("FAIL wrap_count k=%0d: got %0d expected %0d", k, cnt_a(0), ((k - 1) % 50) + 1);
      end
      n_checks++;
      if (tick_a[0] !== ((k == 50 || k == 100) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL wrap_tick k=%0d: got %b", k, tick_a[0]);
      end
    end
    trig_a[0] = 1'b0;
    edge_wait();
    n_checks++;
    if (rp_a[0] !== 1'b1 || lena(0) !== 120 || cnt_a(0) !== 0 || lp_a[0] !== 1'b0) begin
      n_fail++; $display("FAIL wrap_release: got rp %b len %0d count %0d lp %b expected 1 120 0 0",
                         rp_a[0], lena(0), cnt_a(0), lp_a[0]);
    end
    edge_wait();
    n_checks++;
    if (rp_a[0] !== 1'b0 || lena(0) !== 120) begin
      n_fail++; $display("FAIL wrap_after: got rp %b len %0d expected 0 120", rp_a[0], lena(0));
    end
  endtask

  task automatic test_saturate();
    trig_b[1] = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      edge_wait();
      n_checks++;
      if (cnt_b(1) !== ((k < 50) ? k : 50)) begin
        n_fail++; $display("FAIL sat_count k=%0d: got %0d expected %0d", k, cnt_b(1), (k < 50) ? k : 50);
      end
      n_checks++;
      if (tick_b[1] !== ((k == 50) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL sat_tick k=%0d: got %b", k, tick_b[1]);
      end
    end
    trig_b[1] = 1'b0;
    edge_wait();
    n_checks++;
    if (rp_b[1] !== 1'b1 || lenb(1) !== 80 || cnt_b(1) !== 0) begin
      n_fail++; $display("FAIL sat_release: got rp %b len %0d count %0d expected 1 80 0",
                         rp_b[1], lenb(1), cnt_b(1));
    end
  endtask

  task automatic test_long_press();
    trig_a[2] = 1'b1;
    for (int k = 1; k <= 999; k++) begin
      edge_wait();
      n_checks++;
      if (lp_a[2] !== 1'b0) begin
        n_fail++; $display("FAIL long_999 k=%0d: got %b expected 0", k, lp_a[2]);
      end
    end
    trig_a[2] = 1'b0;
    edge_wait();
    n_checks++;
    if (rp_a[2] !== 1'b1 || lena(2) !== 999 || lp_a[2] !== 1'b0) begin
      n_fail++; $display("FAIL long_999_release: got rp %b len %0d lp %b expected 1 999 0",
                         rp_a[2], lena(2), lp_a[2]);
    end
    trig_a[2] = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      edge_wait();
      n_checks++;
      if (lp_a[2] !== ((k == 1000) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL long_1000 k=%0d: got %b", k, lp_a[2]);
      end
    end
    trig_a[2] = 1'b0;
    edge_wait();
    n_checks++;
    if (rp_a[2] !== 1'b1 || lena(2) !== 1000 || lp_a[2] !== 1'b0) begin
      n_fail++; $display("FAIL long_1000_release: got rp %b len %0d lp %b expected 1 1000 0",
                         rp_a[2], lena(2), lp_a[2]);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] pat;
    int exp_cnt [5];
    logic [4:0] exp_rp;
    pat = 5'b01011;  // edges 0..4: 1,1,0,1,0
    exp_cnt = '{1, 2, 0, 1, 0};
    exp_rp  = 5'b10100;
    for (int e = 0; e < 5; e++) begin
      trig_a[3] = pat[e];
      edge_wait();
      n_checks++;
      if (cnt_a(3) !== exp_cnt[e] || rp_a[3] !== exp_rp[e]) begin
        n_fail++; $display("FAIL b2b e=%0d: got count %0d rp %b expected %0d %b",
                           e, cnt_a(3), rp_a[3], exp_cnt[e], exp_rp[e]);
      end
      if (e == 2 || e == 4) begin
        n_checks++;
        if (lena(3) !== ((e == 2) ? 2 : 1)) begin
          n_fail++; $display("FAIL b2b_len e=%0d: got %0d expected %0d", e, lena(3), (e == 2) ? 2 : 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid_press();
    trig_a[0] = 1'b1;
    for (int k = 1; k <= 30; k++) edge_wait();
    n_checks++;
    if (cnt_a(0) !== 30) begin
      n_fail++; $display("FAIL mid_count: got %0d expected 30", cnt_a(0));
    end
    #2 rst_a = 1'b1;
    #1;
    n_checks++;
    if ({count_a, tick_a, lp_a, rp_a, len_a} !== '0) begin
      n_fail++; $display("FAIL mid_reset_async: got %h expected 0", {count_a, tick_a, lp_a, rp_a, len_a});
    end
    edge_wait();
    n_checks++;
    if (rp_a !== '0 || count_a !== '0) begin
      n_fail++; $display("FAIL mid_reset_held: got rp %b count %h expected 0", rp_a, count_a);
    end
    rst_a = 1'b0;
    edge_wait();
    n_checks++;
    if (cnt_a(0) !== 1 || rp_a[0] !== 1'b0 || lena(0) !== 0) begin
      n_fail++; $display("FAIL mid_restart: got count %0d rp %b len %0d expected 1 0 0",
                         cnt_a(0), rp_a[0], lena(0));
    end
    trig_a[0] = 1'b0;
    edge_wait();
    n_checks++;
    if (rp_a[0] !== 1'b1 || lena(0) !== 1) begin
      n_fail++; $display("FAIL mid_release: got rp %b len %0d expected 1 1", rp_a[0], lena(0));
    end
  endtask

  task automatic test_hold_saturation();
    int m_cnt [4];
    int m_hold [4];
    int m_len [4];
    logic [3:0] m_tp, m_tick, m_lp, m_rp, t;
    int nc;
    m_cnt = '{0, 0, 0, 0}; m_hold = '{0, 0, 0, 0}; m_len = '{0, 0, 0, 0};
    m_tp = '0; m_tick = '0; m_lp = '0; m_rp = '0;
    for (int e = 0; e < 40; e++) begin
      t[0] = (e < 20);
      t[1] = ((e % 7) != 0);
      t[2] = (((e / 3) % 2) == 0);
      t[3] = (e >= 5 && e < 17);
      trig_c = t;
      for (int i = 0; i < 4; i++) begin
        if (t[i]) begin
          nc = (m_cnt[i] == 5) ? 1 : m_cnt[i] + 1;
          m_tick[i] = (nc == 5 && m_cnt[i] != 5);
          m_cnt[i]  = nc;
          m_hold[i] = (m_hold[i] == 15) ? 15 : m_hold[i] + 1;
          m_lp[i]   = (m_hold[i] >= 10);
          m_rp[i]   = 1'b0;
        end else begin
          m_rp[i] = m_tp[i];
          if (m_tp[i]) m_len[i] = m_hold[i];
          m_cnt[i] = 0; m_hold[i] = 0; m_tick[i] = 1'b0; m_lp[i] = 1'b0;
        end
      end
      m_tp = t;
      edge_wait();
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (cnt_c(i) !== m_cnt[i] || tick_c[i] !== m_tick[i] || lp_c[i] !== m_lp[i] ||
            rp_c[i] !== m_rp[i] || lenc(i) !== m_len[i]) begin
          n_fail++;
          $display("FAIL hold_sat e=%0d ch=%0d: got cnt %0d tick %b lp %b rp %b len %0d expected %0d %b %b %b %0d",
                   e, i, cnt_c(i), tick_c[i], lp_c[i], rp_c[i], lenc(i),
                   m_cnt[i], m_tick[i], m_lp[i], m_rp[i], m_len[i]);
        end
      end
    end
    n_checks++;
    if (lenc(0) !== 15 || lenc(3) !== 12) begin
      n_fail++; $display("FAIL hold_sat_len: got %0d %0d expected 15 12", lenc(0), lenc(3));
    end
  endtask

  task automatic test_period_one();
    trig_d = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      edge_wait();
      n_checks++;
      if (count_d !== 1'b1 || tick_d !== ((k == 1) ? 1'b1 : 1'b0) || lp_d !== ((k >= 3) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL period_one k=%0d: got count %b tick %b lp %b", k, count_d, tick_d, lp_d);
      end
    end
    trig_d = 1'b0;
    edge_wait();
    n_checks++;
    if (rp_d !== 1'b1 || len_d !== 8'd4 || count_d !== 1'b0) begin
      n_fail++; $display("FAIL period_one_release: got rp %b len %0d count %b expected 1 4 0", rp_d, len_d, count_d);
    end
  endtask

  initial begin
    test_reset();
    test_wrap_count();
    test_saturate();
    test_long_press();
    test_back_to_back();
    test_reset_mid_press();
    test_hold_saturation();
    test_period_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
